// File: rtl/hack_cpu_ctrl_pkg.sv
// Shared types and instruction field positions for the Hack CPU control unit.
package hack_pkg;

  localparam int unsigned PC_W_DEF = 15;
  localparam int unsigned DW_DEF   = 16;

  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    MEMRD,
    EXEC
  } state_t;

  // IR bit positions
  localparam int unsigned A_C     = 15;
  localparam int unsigned ABIT    = 12;
  localparam int unsigned COMP_HI = 11;
  localparam int unsigned COMP_LO = 6;
  localparam int unsigned DEST_A  = 5;
  localparam int unsigned DEST_D  = 4;
  localparam int unsigned DEST_M  = 3;
  localparam int unsigned JMP_LT  = 2;
  localparam int unsigned JMP_EQ  = 1;
  localparam int unsigned JMP_GT  = 0;

endpackage

// File: rtl/hack_jump_cond.sv
// Jump condition evaluation from the C-instruction jump bits and ALU flags.
module hack_jump_cond (
  input  logic [2:0] jmp,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);
  import hack_pkg::*;

  always_comb begin
    take = (jmp[JMP_LT] & ng) | (jmp[JMP_EQ] & zr) | (jmp[JMP_GT] & ~ng & ~zr);
  end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control: fetch/decode, A/D/M/PC registers, ALU drive,
// memory read/write handshake and jump resolution.
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   instr,
  input  logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic [DW-1:0]   alu_x,
  output logic [DW-1:0]   alu_y,
  output logic            alu_zx,
  output logic            alu_nx,
  output logic            alu_zy,
  output logic            alu_ny,
  output logic            alu_f,
  output logic            alu_no,
  input  logic [DW-1:0]   alu_out,
  input  logic            alu_zr,
  input  logic            alu_ng,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_rd_req,
  input  logic            mem_rd_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  output logic            busy
);

  state_t          state, state_nx;
  logic [DW-1:0]   ir, a, d, m;
  logic            take;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc + PC_W'(1);

  hack_jump_cond u_jump (
    .jmp  (ir[JMP_LT:JMP_GT]),
    .zr   (alu_zr),
    .ng   (alu_ng),
    .take (take)
  );

  always_comb begin
    state_nx   = state;
    mem_rd_req = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b1;
    {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = '0;
    case (state)
      FETCH: begin
        busy = 1'b0;
        if (instr_valid) state_nx = DECODE;
      end
      DECODE: begin
        if (!ir[A_C])       state_nx = FETCH;
        else if (ir[ABIT])  state_nx = MEMRD;
        else                state_nx = EXEC;
      end
      MEMRD: begin
        mem_rd_req = 1'b1;
        if (mem_rd_ack) state_nx = EXEC;
      end
      EXEC: begin
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir[COMP_HI:COMP_LO];
        mem_we   = ir[DEST_M];
        state_nx = FETCH;
      end
      default: state_nx = FETCH;
    endcase
  end

  assign alu_x     = d;
  assign alu_y     = ir[ABIT] ? m : a;
  assign mem_addr  = a[PC_W-1:0];
  assign mem_wdata = alu_out;

  // A, D and pc all update on the EXEC edge from pre-edge values, so a jump
  // target always sees the A held before this instruction's own A write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      ir    <= '0;
      a     <= '0;
      d     <= '0;
      m     <= '0;
      pc    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        FETCH:  if (instr_valid) ir <= instr;
        DECODE: begin
          if (!ir[A_C]) begin
            a  <= {{(DW-PC_W){1'b0}}, ir[PC_W-1:0]};
            pc <= pc_inc;
          end
        end
        MEMRD:  if (mem_rd_ack) m <= mem_rdata;
        EXEC: begin
          if (ir[DEST_A]) a <= alu_out;
          if (ir[DEST_D]) d <= alu_out;
          pc <= take ? a[PC_W-1:0] : pc_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed vector bench for hack_cpu_ctrl with a behavioural Hack ALU alongside.
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic [14:0] pc;
  logic [15:0] alu_x, alu_y;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0] alu_out;
  logic        alu_zr, alu_ng;
  logic [14:0] mem_addr;
  logic        mem_rd_req, mem_rd_ack;
  logic [15:0] mem_rdata;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic        busy;

  always #5 clk = ~clk;

  hack_cpu_ctrl #(.PC_W(15), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .pc(pc),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata), .busy(busy)
  );

  // Hack ALU
  logic [15:0] ax, ay;
  always_comb begin
    ax = alu_zx ? 16'h0 : alu_x;
    ax = alu_nx ? ~ax : ax;
    ay = alu_zy ? 16'h0 : alu_y;
    ay = alu_ny ? ~ay : ay;
    alu_out = alu_f ? (ax + ay) : (ax & ay);
    alu_out = alu_no ? ~alu_out : alu_out;
    alu_zr  = (alu_out == 16'h0);
    alu_ng  = alu_out[15];
  end

  typedef struct {
    logic [15:0] instr;
    logic [15:0] rdata;
    int unsigned dly;
    logic [14:0] ea;
    logic [15:0] ed;
    logic [14:0] epc;
    int unsigned ecyc;
    int unsigned ewe;
    logic [14:0] ewa;
    logic [15:0] ewd;
    logic [15:0] ey;
  } vec_t;

  vec_t        vt[24];
  int unsigned ncmp = 0;
  int unsigned nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic [15:0] rd, input int unsigned dly,
                           output int unsigned cyc, output int unsigned wen,
                           output logic [14:0] wa, output logic [15:0] wd,
                           output int unsigned reqn, output logic [5:0] ctl,
                           output logic [15:0] y);
    cyc = 0; wen = 0; reqn = 0; wa = '0; wd = '0; ctl = '0; y = '0;
    instr = ins;
    instr_valid = 1'b1;
    do begin
      if (busy) begin
        ctl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
        y   = alu_y;
        if (mem_we) begin
          wen++;
          wa = mem_addr;
          wd = mem_wdata;
        end
      end
      if (mem_rd_req) begin
        reqn++;
        mem_rd_ack = (reqn >= dly);
        mem_rdata  = rd;
      end else begin
        mem_rd_ack = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      instr_valid = 1'b0;
    end while (busy && cyc < 50);
    mem_rd_ack = 1'b0;
  endtask

  initial begin
    int unsigned cyc, wen, reqn;
    logic [14:0] wa;
    logic [15:0] wd, y, iw;
    logic [5:0]  ctl, ectl;

    //        instr    rdata    dly  A        D        pc       cyc we waddr  wdata    alu_y
    vt[0]  = '{16'h0005, 16'h0000, 0, 15'h0005, 16'h0000, 15'h0001, 2, 0, 15'h0, 16'h0000, 16'h0000};
    vt[1]  = '{16'hEC10, 16'h0000, 0, 15'h0005, 16'h0005, 15'h0002, 3, 0, 15'h0, 16'h0000, 16'h0005};
    vt[2]  = '{16'hE308, 16'h0000, 0, 15'h0005, 16'h0005, 15'h0003, 3, 1, 15'h5, 16'h0005, 16'h0005};
    vt[3]  = '{16'h0007, 16'h0000, 0, 15'h0007, 16'h0005, 15'h0004, 2, 0, 15'h0, 16'h0000, 16'h0000};
    vt[4]  = '{16'hFC10, 16'h1234, 3, 15'h0007, 16'h1234, 15'h0005, 6, 0, 15'h0, 16'h0000, 16'h1234};
    vt[5]  = '{16'h0005, 16'h0000, 0, 15'h0005, 16'h1234, 15'h0006, 2, 0, 15'h0, 16'h0000, 16'h0000};
    vt[6]  = '{16'hEC10, 16'h0000, 0, 15'h0005, 16'h0005, 15'h0007, 3, 0, 15'h0, 16'h0000, 16'h0005};
    vt[7]  = '{16'h0020, 16'h0000, 0, 15'h0020, 16'h0005, 15'h0008, 2, 0, 15'h0, 16'h0000, 16'h0000};
    vt[8]  = '{16'hE301, 16'h0000, 0, 15'h0020, 16'h0005, 15'h0020, 3, 0, 15'h0, 16'h0000, 16'h0020};
    vt[9]  = '{16'hEA90, 16'h0000, 0, 15'h0020, 16'h0000, 15'h0021, 3, 0, 15'h0, 16'h0000, 16'h0020};
    vt[10] = '{16'hE301, 16'h0000, 0, 15'h0020, 16'h0000, 15'h0022, 3, 0, 15'h0, 16'h0000, 16'h0020};
    vt[11] = '{16'hEE90, 16'h0000, 0, 15'h0020, 16'hFFFF, 15'h0023, 3, 0, 15'h0, 16'h0000, 16'h0020};
    vt[12] = '{16'hE301, 16'h0000, 0, 15'h0020, 16'hFFFF, 15'h0024, 3, 0, 15'h0, 16'h0000, 16'h0020};
    vt[13] = '{16'h0005, 16'h0000, 0, 15'h0005, 16'hFFFF, 15'h0025, 2, 0, 15'h0, 16'h0000, 16'h0000};
    vt[14] = '{16'hEC10, 16'h0000, 0, 15'h0005, 16'h0005, 15'h0026, 3, 0, 15'h0, 16'h0000, 16'h0005};
    vt[15] = '{16'h0030, 16'h0000, 0, 15'h0030, 16'h0005, 15'h0027, 2, 0, 15'h0, 16'h0000, 16'h0000};
    vt[16] = '{16'hE321, 16'h0000, 0, 15'h0005, 16'h0005, 15'h0030, 3, 0, 15'h0, 16'h0000, 16'h0030};
    vt[17] = '{16'h7FFF, 16'h0000, 0, 15'h7FFF, 16'h0005, 15'h0031, 2, 0, 15'h0, 16'h0000, 16'h0000};
    vt[18] = '{16'hEAA7, 16'h0000, 0, 15'h0000, 16'h0005, 15'h7FFF, 3, 0, 15'h0, 16'h0000, 16'h7FFF};
    vt[19] = '{16'hEA87, 16'h0000, 0, 15'h0000, 16'h0005, 15'h0000, 3, 0, 15'h0, 16'h0000, 16'h0000};
    vt[20] = '{16'h7FFF, 16'h0000, 0, 15'h7FFF, 16'h0005, 15'h0001, 2, 0, 15'h0, 16'h0000, 16'h0000};
    vt[21] = '{16'hEAA7, 16'h0000, 0, 15'h0000, 16'h0005, 15'h7FFF, 3, 0, 15'h0, 16'h0000, 16'h7FFF};
    vt[22] = '{16'hEA80, 16'h0000, 0, 15'h0000, 16'h0005, 15'h0000, 3, 0, 15'h0, 16'h0000, 16'h0000};
    vt[23] = '{16'hFC10, 16'h00AB, 1, 15'h0000, 16'h00AB, 15'h0001, 4, 0, 15'h0, 16'h0000, 16'h00AB};

    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; mem_rd_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rdreq", 32'(mem_rd_req), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_d", 32'(alu_x), 32'h0);
    chk("rst_a", 32'(mem_addr), 32'h0);
    rst_n = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("stall_busy", 32'(busy), 32'h0);
    chk("stall_pc", 32'(pc), 32'h0);

    for (int i = 0; i < 24; i++) begin
      run_instr(vt[i].instr, vt[i].rdata, vt[i].dly, cyc, wen, wa, wd, reqn, ctl, y);
      iw   = vt[i].instr;
      ectl = iw[15] ? iw[11:6] : 6'b0;
      chk($sformatf("v%0d_cycles", i), cyc, vt[i].ecyc);
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vt[i].epc));
      chk($sformatf("v%0d_a", i), 32'(mem_addr), 32'(vt[i].ea));
      chk($sformatf("v%0d_d", i), 32'(alu_x), 32'(vt[i].ed));
      chk($sformatf("v%0d_we_count", i), wen, vt[i].ewe);
      chk($sformatf("v%0d_ctl", i), 32'(ctl), 32'(ectl));
      chk($sformatf("v%0d_rdreq_cycles", i), reqn, vt[i].dly);
      if (iw[15]) chk($sformatf("v%0d_alu_y", i), 32'(y), 32'(vt[i].ey));
      if (vt[i].ewe != 0) begin
        chk($sformatf("v%0d_waddr", i), 32'(wa), 32'(vt[i].ewa));
        chk($sformatf("v%0d_wdata", i), 32'(wd), 32'(vt[i].ewd));
      end
    end

    // Reset while a read is outstanding, then a stray ack afterwards
    run_instr(16'h0009, 16'h0, 0, cyc, wen, wa, wd, reqn, ctl, y);
    chk("pre_rst_a", 32'(mem_addr), 32'h9);
    instr = 16'hFC10; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("memrd_req", 32'(mem_rd_req), 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrd_pc", 32'(pc), 32'h0);
    chk("midrd_a", 32'(mem_addr), 32'h0);
    chk("midrd_d", 32'(alu_x), 32'h0);
    chk("midrd_rdreq", 32'(mem_rd_req), 32'h0);
    chk("midrd_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    mem_rd_ack = 1'b1; mem_rdata = 16'hBEEF;
    repeat (2) @(posedge clk);
    #1;
    mem_rd_ack = 1'b0;
    chk("stray_busy", 32'(busy), 32'h0);
    chk("stray_pc", 32'(pc), 32'h0);
    chk("stray_d", 32'(alu_x), 32'h0);
    chk("stray_y", 32'(alu_y), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/hack_cpu_ctrl.md
# hack_cpu_ctrl

Multi-cycle control and register unit for the Hack CPU: fetches 16-bit instructions, holds the A, D and PC registers, and drives the combinational ALU's operand and control inputs (zx, nx, zy, ny, f, no). Consumes the ALU's out/zr/ng, writes results back to A/D/memory, and evaluates jump conditions. Sits between instruction ROM, data RAM and the ALU, which is instantiated alongside it at CPU top level.

## Interface
Parameters:
- PC_W, 15, program counter / address width
- DW, 16, data width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; synchronous, active-low
- instr  in  DW  instruction word from ROM at address pc
- instr_valid  in  1  instr is valid this cycle
- pc  out  PC_W  instruction fetch address
- alu_x  out  DW  ALU x operand (D register)
- alu_y  out  DW  ALU y operand (A register, or latched M when a-bit=1)
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control bits
- alu_out  in  DW  ALU result
- alu_zr, alu_ng  in  1 each  ALU zero / negative flags
- mem_addr  out  PC_W  data address (A[14:0])
- mem_rd_req  out  1  data read request
- mem_rd_ack  in  1  read data valid on mem_rdata
- mem_rdata  in  DW  read data
- mem_we  out  1  write strobe, one-cycle pulse
- mem_wdata  out  DW  write data (alu_out)
- busy  out  1  high in every state except FETCH

## Operation
- States: FETCH, DECODE, MEMRD, EXEC.
- FETCH: wait for instr_valid; latch instr into IR; -> DECODE.
- DECODE: IR[15]=0 (A-instr): A <= {1'b0, IR[14:0]}, pc <= pc+1, -> FETCH. IR[15]=1 (C-instr): IR[12]=1 -> MEMRD, else -> EXEC.
- MEMRD: mem_rd_req=1 held until mem_rd_ack; on ack latch mem_rdata into M; -> EXEC.
- EXEC: alu_zx..alu_no = IR[11:6]; alu_y = IR[12] ? M : A; alu_x = D. Outputs from ALU sampled at end of EXEC:
  - dest IR[5] (A): A <= alu_out; IR[4] (D): D <= alu_out; IR[3] (M): mem_we=1 for this cycle, mem_addr = A before update, mem_wdata = alu_out.
  - jump: take = (IR[2]&alu_ng) | (IR[1]&alu_zr) | (IR[0]&~alu_ng&~alu_zr). take: pc <= A[14:0] as held before this instruction's A write; else pc <= pc+1. -> FETCH.
- ALU controls are 0 outside EXEC; alu_x/alu_y reflect register values continuously.
- IR[14:13] ignored.
- pc wraps 0x7FFF -> 0x0000.
- Simultaneous dest A and jump: jump uses old A; A takes new value.

## Timing
- Reset (rst_n=0 at clk edge, any state including mid-MEMRD): pc=0, A=0, D=0, M=0, IR=0, state FETCH, mem_we=0, mem_rd_req=0, ALU controls 0, busy=0. An outstanding read ack arriving after reset is ignored.
- A-instr: 2 cycles (FETCH with valid + DECODE). C-instr without M read: 3 cycles. With M read: 3 + N cycles, N ≥ 1 = cycles until ack (ack sampled from first MEMRD cycle; ack in same cycle as first req gives N=1).
- mem_we asserted only in EXEC, exactly one cycle per instruction with d3=1.
- Register/pc updates visible the cycle after the updating edge.
- instr_valid low in FETCH: stall, no state change.

## Structure
- Package hack_pkg: state enum, IR bit-field positions (A_C, ABIT, COMP, DEST_A/D/M, JMP_LT/EQ/GT), PC_W/DW defaults.
- One sub-module: hack_jump_cond (combinational: jmp[2:0], zr, ng -> take).
- ALU not instantiated inside this block.

## Test plan
- Reset mid-MEMRD (ack withheld) -> next cycle pc=0, A=D=0, mem_rd_req=0, busy=0; later stray ack causes no change.
- 0x0005 (@5) -> after 2 cycles A=5, pc=1, no mem_we.
- A=5, 0xEC10 (D=A) -> in EXEC controls 110000, alu_y=5; afterwards D=5, pc+1.
- A=5, D=5, 0xE308 (M=D) -> one mem_we pulse, mem_addr=5, mem_wdata=5; A, D unchanged.
- A=7, 0xFC10 (D=M), ack delayed 3 cycles with mem_rdata=0x1234 -> mem_rd_req high 3 cycles, alu_y=0x1234 in EXEC, D=0x1234; instruction takes 6 cycles.
- A=0x0020, 0xE301 (D;JGT): D=5 -> pc=0x20; D=0 -> pc+1; D=0xFFFF -> pc+1. 0xEA87 (0;JMP) at pc=0x7FFF with A=0 -> pc=0; no-jump at 0x7FFF -> pc=0 (wrap).
